// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle for down_timer.
// The pause signal exists only when DOWN_TIMER_PAUSE_EN is defined.
interface down_timer_if #(parameter int N = 8, parameter int P = 4);
   logic         start;
   logic         stop;
   logic         load;
   logic [N-1:0] d;
   logic [P-1:0] presc;
   logic         auto_reload;
   logic [N-1:0] q;
   logic         busy;
   logic         done;
   logic         zero_tick;
`ifdef DOWN_TIMER_PAUSE_EN
   logic         pause;
   modport master (output start, stop, load, d, presc, auto_reload, pause,
                   input q, busy, done, zero_tick);
   modport slave  (input start, stop, load, d, presc, auto_reload, pause,
                   output q, busy, done, zero_tick);
`else
   modport master (output start, stop, load, d, presc, auto_reload,
                   input q, busy, done, zero_tick);
   modport slave  (input start, stop, load, d, presc, auto_reload,
                   output q, busy, done, zero_tick);
`endif
endinterface

// File: rtl/down_timer.sv
// down_timer: prescaled down counter with start/stop, auto-reload and one-cycle expiry pulse.
// Optional DOWN_TIMER_PAUSE_EN adds a pause input that freezes counting while RUN.
module down_timer #(
   parameter int N = 8,
   parameter int P = 4
) (
   input logic         clk,
   input logic         reset,
   down_timer_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [N-1:0] q, q_n, rld, rld_n;
   logic [P-1:0] p_cnt, p_n;
   logic done, done_n, pause;
`ifdef DOWN_TIMER_PAUSE_EN
   assign pause = bus.pause;
`else
   assign pause = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         q     <= '0;
         rld   <= '0;
         p_cnt <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         q     <= q_n;
         rld   <= rld_n;
         p_cnt <= p_n;
         done  <= done_n;
      end
   end
   // Expiry is detected at q==1 so the count never wraps below zero.
   always_comb begin
      state_n = state;
      q_n     = q;
      rld_n   = rld;
      p_n     = p_cnt;
      done_n  = 1'b0;
      if (state == IDLE) begin
         if (bus.load) begin
            q_n   = bus.d;
            rld_n = bus.d;
         end else if (bus.start) begin
            if (q != '0) begin
               state_n = RUN;
               p_n     = bus.presc;
            end else begin
               done_n = 1'b1;
            end
         end
      end else if (bus.stop) begin
         state_n = IDLE;
      end else begin
         if (bus.load) rld_n = bus.d;
         if (!pause) begin
            if (p_cnt == '0) begin
               p_n = bus.presc;
               if (q > N'(1)) begin
                  q_n = q - N'(1);
               end else if (bus.auto_reload && rld != '0) begin
                  q_n    = rld;
                  done_n = 1'b1;
               end else begin
                  q_n     = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end else begin
               p_n = p_cnt - P'(1);
            end
         end
      end
   end
   assign bus.q         = q;
   assign bus.busy      = (state == RUN);
   assign bus.done      = done;
   assign bus.zero_tick = (q == '0);
endmodule
